// File: rtl/aes_model_pack.sv
// Shared AES datapath types and GF(2^8) helpers for the aes_128 round pipeline.
// Constant multiplies are xtime chains, so no lookup ROM is inferred.
package aes_model_pack;

   localparam int         COLUMN_SIZE_IN_BYTES = 4;
   localparam logic [7:0] AES_POLY             = 8'h1b;

   typedef logic [COLUMN_SIZE_IN_BYTES-1:0][7:0]      column_t;
   typedef logic [3:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] state_t;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Only the coefficients up to 0x0f are needed (02,03,01,0e,0b,0d,09).
   function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

endpackage

// File: rtl/mix_column_lane.sv
// One combinational MixColumns / InvMixColumns column; zero latency, no flow control.
// The coefficient rotation is shared, only the four constants change with inverse.
module mix_column_lane
   import aes_model_pack::*;
(
   input  column_t a,
   input  logic    inverse,
   output column_t y
);

   logic [3:0] k0, k1, k2, k3;

   assign k0 = inverse ? 4'he : 4'h2;
   assign k1 = inverse ? 4'hb : 4'h3;
   assign k2 = inverse ? 4'hd : 4'h1;
   assign k3 = inverse ? 4'h9 : 4'h1;

   for (genvar r = 0; r < 4; r++) begin : g_row
      assign y[r] = gf_mul_const(a[r], k0) ^
                    gf_mul_const(a[(r+1)%4], k1) ^
                    gf_mul_const(a[(r+2)%4], k2) ^
                    gf_mul_const(a[(r+3)%4], k3);
   end

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential MixColumns engine: LANES columns per cycle, GROUPS cycles accept-to-out_valid.
// Holds the result while out_ready is low; accepts a new state in DONE on the out handshake edge.
module mix_columns_engine
   import aes_model_pack::*;
#(
   parameter int NUM_COLUMNS = 4,
   parameter int LANES       = 1
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic                                           in_inverse,
   input  logic [NUM_COLUMNS-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] in_state,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [NUM_COLUMNS-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] out_state
);

   localparam int GROUPS = NUM_COLUMNS / LANES;
   localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int IW     = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4) || (NUM_COLUMNS % LANES) != 0) begin : g_bad_lanes
      $error("mix_columns_engine: LANES must be 1, 2 or 4 and divide NUM_COLUMNS");
   end

   mc_fsm_e state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          mode_q;
   logic [NUM_COLUMNS-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] work_q, work_d;
   logic [LANES-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0]       lane_in, lane_out;
   logic [IW-1:0] grp_base;
   logic          accept, last_grp;

   assign accept   = in_valid && in_ready;
   assign last_grp = (cnt_q == CW'(GROUPS - 1));
   assign grp_base = IW'(cnt_q * LANES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= MC_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MC_IDLE: if (accept)   state_d = MC_BUSY;
         MC_BUSY: if (last_grp) state_d = MC_DONE;
         MC_DONE: if (out_ready) state_d = in_valid ? MC_BUSY : MC_IDLE;
         default: state_d = MC_IDLE;
      endcase
   end

   // in_ready depends only on FSM state and out_ready, never on in_valid.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         MC_IDLE: in_ready = 1'b1;
         MC_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   assign lane_in = work_q[grp_base +: LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      mix_column_lane u_lane (
         .a       (lane_in[l]),
         .inverse (mode_q),
         .y       (lane_out[l])
      );
   end

   always_comb begin
      work_d = work_q;
      work_d[grp_base +: LANES] = lane_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else if (accept) begin
         work_q <= in_state;
         mode_q <= in_inverse;
         cnt_q  <= '0;
      end else if (state_q == MC_BUSY) begin
         work_q <= work_d;
         cnt_q  <= last_grp ? '0 : cnt_q + 1'b1;
      end
   end

   assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed and random-stream bench for mix_columns_engine with a shift-and-add GF model.
module tb_mix_columns_engine;

   parameter int LANES  = 1;
   localparam int GROUPS = 4 / LANES;

   typedef logic [3:0][3:0][7:0] st_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic in_inverse = 1'b0;
   st_t  in_state = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   st_t  out_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mix_columns_engine #(.NUM_COLUMNS(4), .LANES(LANES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_inverse (in_inverse),
      .in_state   (in_state),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_state  (out_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Columns written as row0..row3 left to right, as in the AES documents.
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic st_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
      return {bswap(w3), bswap(w2), bswap(w1), bswap(w0)};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      repeat (8) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] mcol(input logic [31:0] c, input logic inv);
      logic [7:0] a0, a1, a2, a3, k0, k1, k2, k3, o0, o1, o2, o3;
      {a3, a2, a1, a0} = c;
      k0 = inv ? 8'h0e : 8'h02;
      k1 = inv ? 8'h0b : 8'h03;
      k2 = inv ? 8'h0d : 8'h01;
      k3 = inv ? 8'h09 : 8'h01;
      o0 = gmul(a0, k0) ^ gmul(a1, k1) ^ gmul(a2, k2) ^ gmul(a3, k3);
      o1 = gmul(a1, k0) ^ gmul(a2, k1) ^ gmul(a3, k2) ^ gmul(a0, k3);
      o2 = gmul(a2, k0) ^ gmul(a3, k1) ^ gmul(a0, k2) ^ gmul(a1, k3);
      o3 = gmul(a3, k0) ^ gmul(a0, k1) ^ gmul(a1, k2) ^ gmul(a2, k3);
      return {o3, o2, o1, o0};
   endfunction

   function automatic st_t mstate(input st_t s, input logic inv);
      return {mcol(s[3], inv), mcol(s[2], inv), mcol(s[1], inv), mcol(s[0], inv)};
   endfunction

   task automatic send(input st_t s, input logic inv);
      int w;
      w = 0;
      in_valid   = 1'b1;
      in_state   = s;
      in_inverse = inv;
      while (!in_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) check("done_timeout", 0, 1);
   endtask

   task automatic recv();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   st_t  va, vexp, vc, vcexp;
   st_t  ss [8];
   logic sm [8];
   int   n, k, b, last;

   initial begin
      va    = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
      vexp  = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
      vc    = mk(32'hc6c6c6c6, 32'h01010101, 32'h00000000, 32'hd4d4d4d5);
      vcexp = mk(32'hc6c6c6c6, 32'h01010101, 32'h00000000, 32'hd5d5d7d6);

      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_state", out_state, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Forward known vector and latency.
      send(va, 1'b0);
      check("busy_in_ready", in_ready, 0);
      wait_done(n);
      check("lat_fwd", n, GROUPS);
      check("fwd_state", out_state, vexp);
      check("done_in_ready_hold", in_ready, 0);
      recv();

      // Inverse; inputs scrambled right after accept must not matter.
      send(vexp, 1'b1);
      in_inverse = 1'b0;
      in_state   = '1;
      wait_done(n);
      check("lat_inv", n, GROUPS);
      check("inv_state", out_state, va);
      recv();

      // c6 column is a fixed point in both directions.
      send(vc, 1'b0);
      wait_done(n);
      check("c6_fwd", out_state, vcexp);
      check("c6_fwd_col", out_state[0], 32'hc6c6c6c6);
      recv();
      send(vcexp, 1'b1);
      wait_done(n);
      check("c6_inv", out_state, vc);
      recv();

      // Backpressure then simultaneous out/in handshake.
      send(va, 1'b0);
      wait_done(n);
      repeat (5) begin
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_state", out_state, vexp);
         @(posedge clk); #1;
      end
      in_valid   = 1'b1;
      in_state   = vexp;
      in_inverse = 1'b1;
      out_ready  = 1'b1;
      #1;
      check("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_busy", out_valid, 0);
      wait_done(n);
      check("b2b_lat", n, GROUPS);
      check("b2b_state", out_state, va);
      recv();

      // Streaming: random states, out_ready held high.
      for (int i = 0; i < 8; i++) begin
         ss[i] = {$urandom, $urandom, $urandom, $urandom};
         sm[i] = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      k = 0; b = 0; last = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               int w;
               w = 0;
               in_valid   = 1'b1;
               in_state   = ss[i];
               in_inverse = sm[i];
               while (!in_ready && w < 100) begin
                  @(posedge clk); #1;
                  w++;
               end
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            while (k < 8 && b < 400) begin
               if (out_valid) begin
                  check($sformatf("stream_%0d", k), out_state, mstate(ss[k], sm[k]));
                  if (k > 0) check($sformatf("period_%0d", k), cyc - last, GROUPS + 1);
                  last = cyc;
                  k++;
               end
               @(posedge clk); #1;
               b++;
            end
            if (k < 8) check("stream_timeout", k, 8);
         end
      join
      out_ready = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a computation.
      send(va, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_state", out_state, 0);
      check("mid_rst_in_ready", in_ready, 1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send(vc, 1'b0);
      wait_done(n);
      check("post_rst_lat", n, GROUPS);
      check("post_rst_state", out_state, vcexp);
      recv();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Parametrised, sequential AES MixColumns / InvMixColumns engine for the aes_128 datapath. It accepts a full state of NUM_COLUMNS 32-bit columns over a valid/ready handshake and processes LANES columns per clock. It returns the mixed state over a second valid/ready handshake. It sits between the ShiftRows and AddRoundKey stages of the round pipeline, and its per-request mode bit lets one instance serve both encryption and decryption.

## Interface
- NUM_COLUMNS, 4, columns per state; state width = NUM_COLUMNS*COLUMN_SIZE_IN_BYTES*8 bits.
- LANES, 1, columns mixed per cycle; legal values divide NUM_COLUMNS (1, 2, 4); otherwise elaboration fails.
- Derived: GROUPS = NUM_COLUMNS/LANES; counter width = $clog2(GROUPS), minimum 1.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state offered.
- in_ready  out  1  engine can accept.
- in_inverse  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with the state.
- in_state  in  [NUM_COLUMNS-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0]  column c, byte r = row r.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_state  out  same as in_state  mixed state.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept = in_valid && in_ready. On accept:
  - latch in_state into the work register and in_inverse into the mode register;
  - clear the group counter;
  - go to BUSY.
- BUSY, each cycle:
  - columns [cnt*LANES +: LANES] pass through LANES mix lanes;
  - results are written back into the same positions of the work register;
  - cnt increments.
  - After group GROUPS-1 is written, go to DONE.
- DONE, when out_ready=1:
  - if in_valid is also 1, accept the new state and go to BUSY (back-to-back);
  - otherwise go to IDLE.
- Forward lane: out_r = 02·a_r ⊕ 03·a_{r+1} ⊕ a_{r+2} ⊕ a_{r+3}, with indices mod 4.
- Inverse lane: coefficients 0e, 0b, 0d, 09 in the same rotation.
- GF(2^8) arithmetic uses polynomial 0x11b. Multiplication is xtime chains only, with no lookup ROM.
- out_state is driven from the work register. It is meaningful only while out_valid=1.
- in_state and in_inverse changes while BUSY or DONE are ignored.

## Timing
- Reset values (asynchronous on rst_n low):
  - FSM = IDLE, in_ready=1;
  - out_valid=0, out_state=0;
  - counter=0, mode=0.
- Reset mid-BUSY or mid-DONE discards the state; no partial result is ever presented.
- Latency: accept edge to out_valid high = GROUPS cycles. This is 4 for LANES=1 and 1 for LANES=4.
- Throughput with out_ready held high and in_valid streaming: one state per GROUPS+1 cycles.
- Backpressure: while out_valid && !out_ready, out_state and out_valid hold stable and no input is accepted.
- Simultaneous out handshake and in handshake in DONE: both complete on the same edge. The new state overwrites the work register on that edge.
- Counter wrap: the counter resets on every accept. It never wraps during BUSY.
- in_ready is combinational from the FSM state and out_ready. There is no path from in_valid to in_ready.

## Structure
- aes_model_pack holds COLUMN_SIZE_IN_BYTES (existing) plus the new items:
  - state/column typedefs;
  - xtime and gf_mul_const functions;
  - the AES polynomial constant 8'h1b.
- Sub-module mix_column_lane: a combinational single column with an inverse select input, instantiated LANES times via generate.
- The engine holds the FSM, counter, mode and work registers.

## Test plan
- Forward, LANES=1: state columns {db,13,53,45},{f2,0a,22,5c},{01,01,01,01},{d4,d4,d4,d5} -> {8e,4d,a1,bc},{9f,dc,58,9d},{01,01,01,01},{d5,d5,d7,d6}. out_valid rises exactly 4 cycles after accept.
- Inverse: feed the forward output above with in_inverse=1 -> the original state returned; the mode bit is toggled after accept to prove it is latched.
- LANES=4 and LANES=2 builds: same vectors -> identical results with latencies 1 and 2. Column {c6,c6,c6,c6} is unchanged in both modes.
- Backpressure: out_ready low for 5 cycles in DONE -> out_state stable, in_ready=0. Release with in_valid high -> both handshakes on one edge and the next result is correct.
- Back-to-back stream of 8 random states against the model -> all match, one result per GROUPS+1 cycles.
- rst_n pulsed low mid-BUSY -> out_valid=0, out_state=0 and in_ready=1 immediately. The next request completes correctly.
